// File: rtl/mat_wb_seq.sv
// Writeback sequencer: turns retiring write-select classes into register-file
// write strobes, serialising whole-matrix writes into back-to-back row writes.
module mat_wb_seq #(
   parameter  int XLEN  = 32,
   parameter  int MROWS = 4,
   parameter  int MCOLS = 4,
   parameter  int MREGS = 4,
   localparam int RW    = MCOLS * XLEN,
   localparam int MIDX  = (MREGS > 1) ? $clog2(MREGS) : 1,
   localparam int RB    = $clog2(MROWS)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wb_valid,
   output logic                  wb_ready,
   input  logic [1:0]            wb_w_select,
   input  logic [4:0]            wb_rd,
   input  logic [RB-1:0]         wb_slice_idx,
   input  logic [XLEN-1:0]       wb_reg_data,
   input  logic [MROWS*RW-1:0]   wb_mat_data,
   output logic                  reg_we,
   output logic [4:0]            reg_waddr,
   output logic [XLEN-1:0]       reg_wdata,
   output logic                  mat_we,
   output logic [MIDX-1:0]       mat_waddr,
   output logic [RB-1:0]         mat_row,
   output logic [RW-1:0]         mat_wdata,
   output logic                  mat_last,
   output logic                  busy
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t              state_reg, state_next;
   logic [RB-1:0]       row_cnt_reg, row_cnt_next;
   logic [MROWS*RW-1:0] mat_buf_reg;
   logic [MIDX-1:0]     dst_reg;

   logic                reg_we_reg, reg_we_next;
   logic [4:0]          reg_waddr_reg, reg_waddr_next;
   logic [XLEN-1:0]     reg_wdata_reg, reg_wdata_next;
   logic                mat_we_reg, mat_we_next;
   logic [MIDX-1:0]     mat_waddr_reg, mat_waddr_next;
   logic [RB-1:0]       mat_row_reg, mat_row_next;
   logic [RW-1:0]       mat_wdata_reg, mat_wdata_next;
   logic                mat_last_reg, mat_last_next;

   logic [RW-1:0]       buf_row [MROWS];
   logic [RB-1:0]       row_inc;
   logic                last_row;
   logic                accept;
   logic                burst_cont;

   for (genvar gi = 0; gi < MROWS; gi++) begin : g_row
      assign buf_row[gi] = mat_buf_reg[gi*RW +: RW];
   end

   // row_cnt always names the row currently presented on the mat_* outputs
   assign row_inc    = row_cnt_reg + RB'(1);
   assign last_row   = (row_cnt_reg == RB'(MROWS - 1));
   assign burst_cont = (state_reg == BURST) && !last_row;
   assign wb_ready   = (state_reg == IDLE) || last_row;
   assign accept     = wb_valid && wb_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg     <= IDLE;
         row_cnt_reg   <= '0;
         reg_we_reg    <= 1'b0;
         reg_waddr_reg <= '0;
         reg_wdata_reg <= '0;
         mat_we_reg    <= 1'b0;
         mat_waddr_reg <= '0;
         mat_row_reg   <= '0;
         mat_wdata_reg <= '0;
         mat_last_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         row_cnt_reg   <= row_cnt_next;
         reg_we_reg    <= reg_we_next;
         reg_waddr_reg <= reg_waddr_next;
         reg_wdata_reg <= reg_wdata_next;
         mat_we_reg    <= mat_we_next;
         mat_waddr_reg <= mat_waddr_next;
         mat_row_reg   <= mat_row_next;
         mat_wdata_reg <= mat_wdata_next;
         mat_last_reg  <= mat_last_next;
      end
   end

   // Burst buffer isolates the remaining rows from upstream changes
   always_ff @(posedge clk) begin
      if (accept && wb_w_select == 2'b11) begin
         mat_buf_reg <= wb_mat_data;
         dst_reg     <= wb_rd[MIDX-1:0];
      end
   end

   always_comb begin
      state_next   = IDLE;
      row_cnt_next = '0;
      if (burst_cont) begin
         state_next   = BURST;
         row_cnt_next = row_inc;
      end else if (accept && wb_w_select == 2'b11) begin
         state_next   = BURST;
         row_cnt_next = '0;
      end
   end

   always_comb begin
      reg_we_next    = 1'b0;
      reg_waddr_next = reg_waddr_reg;
      reg_wdata_next = reg_wdata_reg;
      mat_we_next    = 1'b0;
      mat_waddr_next = mat_waddr_reg;
      mat_row_next   = mat_row_reg;
      mat_wdata_next = mat_wdata_reg;
      mat_last_next  = 1'b0;
      if (burst_cont) begin
         mat_we_next    = 1'b1;
         mat_waddr_next = dst_reg;
         mat_row_next   = row_inc;
         mat_wdata_next = buf_row[row_inc];
         mat_last_next  = (row_inc == RB'(MROWS - 1));
      end else if (accept) begin
         case (wb_w_select)
            2'b01: begin
               if (wb_rd != 5'd0) begin
                  reg_we_next    = 1'b1;
                  reg_waddr_next = wb_rd;
                  reg_wdata_next = wb_reg_data;
               end
            end
            2'b10: begin
               mat_we_next    = 1'b1;
               mat_waddr_next = wb_rd[MIDX-1:0];
               mat_row_next   = wb_slice_idx;
               mat_wdata_next = wb_mat_data[RW-1:0];
               mat_last_next  = 1'b1;
            end
            2'b11: begin
               mat_we_next    = 1'b1;
               mat_waddr_next = wb_rd[MIDX-1:0];
               mat_row_next   = '0;
               mat_wdata_next = wb_mat_data[RW-1:0];
            end
            default: ;
         endcase
      end
   end

   assign reg_we    = reg_we_reg;
   assign reg_waddr = reg_waddr_reg;
   assign reg_wdata = reg_wdata_reg;
   assign mat_we    = mat_we_reg;
   assign mat_waddr = mat_waddr_reg;
   assign mat_row   = mat_row_reg;
   assign mat_wdata = mat_wdata_reg;
   assign mat_last  = mat_last_reg;
   assign busy      = (state_reg == BURST);

endmodule

// File: tb/tb_mat_wb_seq.sv
// Randomized scoreboard bench for mat_wb_seq: the stimulus side predicts every
// write (cycle, port, fields); a negedge monitor pops and compares.
module tb_mat_wb_seq;
   localparam int XLEN = 32, MROWS = 4, MCOLS = 4, MREGS = 4;
   localparam int RW = MCOLS * XLEN;

   logic               clk = 1'b0;
   logic               rstn;
   logic               wb_valid;
   logic               wb_ready;
   logic [1:0]         wb_w_select;
   logic [4:0]         wb_rd;
   logic [1:0]         wb_slice_idx;
   logic [XLEN-1:0]    wb_reg_data;
   logic [MROWS*RW-1:0] wb_mat_data;
   logic               reg_we;
   logic [4:0]         reg_waddr;
   logic [XLEN-1:0]    reg_wdata;
   logic               mat_we;
   logic [1:0]         mat_waddr;
   logic [1:0]         mat_row;
   logic [RW-1:0]      mat_wdata;
   logic               mat_last;
   logic               busy;

   mat_wb_seq #(.XLEN(XLEN), .MROWS(MROWS), .MCOLS(MCOLS), .MREGS(MREGS)) dut (
      .clk(clk), .rstn(rstn), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_w_select(wb_w_select), .wb_rd(wb_rd), .wb_slice_idx(wb_slice_idx),
      .wb_reg_data(wb_reg_data), .wb_mat_data(wb_mat_data),
      .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .mat_we(mat_we), .mat_waddr(mat_waddr), .mat_row(mat_row),
      .mat_wdata(mat_wdata), .mat_last(mat_last), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           cyc;
      bit           is_mat;
      logic [4:0]   addr;
      logic [1:0]   row;
      logic [127:0] data;
      bit           last;
   } exp_t;

   exp_t         q[$];
   int           tests = 0, fails = 0;
   int           cyc = 0;
   int           bstart = 1, blast = 0;
   logic [4:0]   last_reg_addr;
   logic [31:0]  last_reg_data;
   logic [1:0]   last_mat_addr, last_mat_row;
   logic [127:0] last_mat_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [MROWS*RW-1:0] rnd_mat();
      logic [MROWS*RW-1:0] v;
      for (int i = 0; i < MROWS*RW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic void model_reset();
      q.delete();
      bstart = 1; blast = 0;
      last_reg_addr = '0; last_reg_data = '0;
      last_mat_addr = '0; last_mat_row = '0; last_mat_data = '0;
   endfunction

   // Reference: an accepted request at edge p yields its writes starting in cycle p
   function automatic void model_accept(input int p, input logic [1:0] sel, input logic [4:0] rd,
                                        input logic [1:0] sl, input logic [31:0] rdat,
                                        input logic [MROWS*RW-1:0] mdat);
      exp_t e;
      e.cyc = p; e.addr = rd; e.row = 0; e.last = 0; e.is_mat = 0; e.data = '0;
      case (sel)
         2'b01: if (rd != 0) begin e.data = {96'd0, rdat}; q.push_back(e); end
         2'b10: begin
            e.is_mat = 1; e.addr = 5'(rd % MREGS); e.row = sl;
            e.data = mdat[RW-1:0]; e.last = 1; q.push_back(e);
         end
         2'b11: begin
            for (int k = 0; k < MROWS; k++) begin
               e.cyc = p + k; e.is_mat = 1; e.addr = 5'(rd % MREGS); e.row = 2'(k);
               e.data = mdat[k*RW +: RW]; e.last = (k == MROWS - 1); q.push_back(e);
            end
            bstart = p; blast = p + MROWS - 1;
         end
         default: ;
      endcase
   endfunction

   task automatic issue(input bit v, input logic [1:0] sel, input logic [4:0] rd, input logic [1:0] sl,
                        input logic [31:0] rdat, input logic [MROWS*RW-1:0] mdat);
      int  waits = 0;
      bit  acc = 0;
      bit  exp_busy, exp_ready;
      do begin
         @(negedge clk);
         wb_valid = v; wb_w_select = sel; wb_rd = rd; wb_slice_idx = sl;
         wb_reg_data = rdat; wb_mat_data = mdat;
         if (waits > 0 && sel[1] == 1'b0) wb_mat_data = rnd_mat();
         exp_busy  = (cyc >= bstart) && (cyc <= blast);
         exp_ready = !exp_busy || (cyc == blast);
         chk("busy", busy, exp_busy);
         chk("wb_ready", wb_ready, exp_ready);
         acc = v && exp_ready;
         if (acc) model_accept(cyc + 1, sel, rd, sl, rdat, mdat);
         waits++;
      end while (v && !acc && waits < 20);
      if (v && !acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         issue(0, 2'($urandom), 5'($urandom), 2'($urandom), $urandom, rnd_mat());
   endtask

   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (reg_we && mat_we) chk("both_we", 1, 0);
         if (reg_we || mat_we) begin
            if (q.size() == 0) begin
               chk("spurious_write", {reg_we, mat_we}, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               $display("[TB] cyc %0d %s addr=%0d row=%0d data=%0h last=%0d", cyc,
                        mat_we ? "MAT" : "REG", mat_we ? 32'(mat_waddr) : 32'(reg_waddr),
                        mat_row, mat_we ? mat_wdata : {96'd0, reg_wdata}, mat_last);
               chk("write_cycle", cyc, e.cyc);
               chk("mat_we", mat_we, e.is_mat);
               chk("reg_we", reg_we, !e.is_mat);
               if (e.is_mat) begin
                  chk("mat_waddr", mat_waddr, e.addr);
                  chk("mat_row", mat_row, e.row);
                  chk("mat_wdata", mat_wdata, e.data);
                  chk("mat_last", mat_last, e.last);
                  last_mat_addr = e.addr[1:0]; last_mat_row = e.row; last_mat_data = e.data;
               end else begin
                  chk("reg_waddr", reg_waddr, e.addr);
                  chk("reg_wdata", reg_wdata, e.data);
                  last_reg_addr = e.addr; last_reg_data = e.data[31:0];
               end
            end
         end
         if (!reg_we) begin
            chk("reg_waddr_hold", reg_waddr, last_reg_addr);
            chk("reg_wdata_hold", reg_wdata, last_reg_data);
         end
         if (!mat_we) begin
            chk("mat_waddr_hold", mat_waddr, last_mat_addr);
            chk("mat_row_hold", mat_row, last_mat_row);
            chk("mat_wdata_hold", mat_wdata, last_mat_data);
         end
      end
   end

   initial begin
      logic [127:0] r0, r1, r2, r3, s0;
      rstn = 1'b0; wb_valid = 0; wb_w_select = 0; wb_rd = 0; wb_slice_idx = 0;
      wb_reg_data = 0; wb_mat_data = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_reg_we", reg_we, 0);
      chk("rst_mat_we", mat_we, 0);
      chk("rst_mat_last", mat_last, 0);
      chk("rst_wb_ready", wb_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_reg_waddr", reg_waddr, 0);
      chk("rst_mat_wdata", mat_wdata, 0);
      #2 rstn = 1'b1;
      idle(10);

      // scalar writes, including x0
      issue(1, 2'b01, 5'd5, 2'd0, 32'hDEADBEEF, rnd_mat());
      idle(2);
      issue(1, 2'b01, 5'd0, 2'd0, 32'h12345678, rnd_mat());
      idle(3);

      // slice write
      s0 = 128'h11112222_33334444_55556666_77778888;
      issue(1, 2'b10, 5'd2, 2'd3, $urandom, {rnd_mat() >> RW, s0});
      idle(2);

      // whole-matrix burst, then a held scalar request lands back-to-back
      r0 = {4{32'hAAAAAAAA}}; r1 = {4{32'hBBBBBBBB}}; r2 = {4{32'hCCCCCCCC}}; r3 = {4{32'hDDDDDDDD}};
      issue(1, 2'b11, 5'd1, 2'd0, $urandom, {r3, r2, r1, r0});
      issue(1, 2'b01, 5'd7, 2'd0, 32'h5, rnd_mat());
      idle(4);

      // reset during row 1 of a burst
      issue(1, 2'b11, 5'd3, 2'd0, $urandom, rnd_mat());
      @(posedge clk); #1 wb_valid = 0;
      @(posedge clk); #2 rstn = 1'b0;
      #1 chk("mid_reset_mat_we", mat_we, 0);
      chk("mid_reset_busy", busy, 0);
      model_reset();
      @(negedge clk); #2 rstn = 1'b1;
      idle(8);

      // null requests
      for (int i = 0; i < 3; i++) issue(1, 2'b00, 5'($urandom), 2'($urandom), $urandom, rnd_mat());
      idle(2);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         issue(1, 2'($urandom), 5'($urandom_range(0, 31)), 2'($urandom), $urandom, rnd_mat());
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(8);
      chk("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
